console_rx: RTL and testbench

- Serial receiver that sits directly downstream of the console transmitter's `tx` line. In benches and loopback builds, `console.tx` connects straight to `rx`.
- Oversamples an 8N1 asynchronous stream, reassembles bytes and buffers them in a FIFO.
- Presents bytes on a valid/ready stream to a checker or a Wishbone-facing wrapper.
- Flags framing errors and overruns.

---
 rtl/console_rx.sv | 217 +++++++++++++++++++++
 tb/tb_console_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/console_rx.sv
// console_rx: 8N1 serial receiver with a first-word-fall-through receive FIFO.
// The rx line is double-flopped, frames are sampled at bit midpoints and
// complete bytes are presented on a valid/ready stream.
//
// Optional build macro: CONSOLE_RX_PARITY_EN
//   When defined, frames are 8E1: a PARITY state samples one extra bit and
//   the parity_err output pulses when the even-parity check fails. The byte
//   is still pushed as long as the stop bit is high.
//
// Stream handshake: data_out is meaningful only while valid=1; a byte is
// consumed at a posedge where valid && ready, and the next entry (if any)
// appears the following cycle. ready while valid=0 has no effect.
module console_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [7:0]                    data_out,
    output logic                          valid,
    input  logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun,
`ifdef CONSOLE_RX_PARITY_EN
    output logic                          parity_err,
`endif
    output logic [2:0]                    o_dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    // Last count value of a full bit period, and of the half period used to
    // land in the middle of the start bit.
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef CONSOLE_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic          r_rx_meta;
    logic          r_rx_s;
    logic [2:0]    r_state;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
`ifdef CONSOLE_RX_PARITY_EN
    logic          r_par_bit;
    logic          r_parity_err;
`endif
    logic          r_frame_err;
    logic          r_overrun;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;

    logic          w_bit_tick;
    logic          w_stop_sample;
    logic          w_push;
    logic          w_frame_bad;
    logic          w_full;
    logic          w_pop;
    logic          w_wr_en;

    assign w_bit_tick    = (r_clk_cnt == CNT_LAST);
    assign w_stop_sample = (r_state == S_STOP) && w_bit_tick;
    assign w_push        = w_stop_sample && r_rx_s;
    assign w_frame_bad   = w_stop_sample && !r_rx_s;

    // Extra pointer MSB separates full from empty.
    assign count    = r_wr_ptr - r_rd_ptr;
    assign valid    = (count != '0);
    assign w_full   = (count == (AW + 1)'(FIFO_DEPTH));
    assign w_pop    = valid && ready;
    // A push into a full FIFO still lands if the head leaves in the same cycle.
    assign w_wr_en  = w_push && (!w_full || w_pop);
    assign data_out = valid ? r_mem[r_rd_ptr[AW-1:0]] : 8'h00;

    assign frame_err   = r_frame_err;
    assign overrun     = r_overrun;
    assign o_dbg_state = r_state;
`ifdef CONSOLE_RX_PARITY_EN
    assign parity_err  = r_parity_err;
`endif

    // Two-flop synchronizer; the line idles high so reset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Frame FSM: find the start edge, then sample each bit at its midpoint.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
`ifdef CONSOLE_RX_PARITY_EN
            r_par_bit <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state   <= S_START;
                        r_clk_cnt <= '0;
                    end
                end
                S_START: begin
                    if (r_clk_cnt == CNT_HALF) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                        // A line already back high at mid-start was a glitch.
                        r_state   <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_tick) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef CONSOLE_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`ifdef CONSOLE_RX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_tick) begin
                        r_clk_cnt <= '0;
                        r_par_bit <= r_rx_s;
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    // Leave at mid-stop-bit so a back-to-back start is not missed.
                    if (w_bit_tick) begin
                        r_clk_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_clk_cnt <= '0;
                end
            endcase
        end
    end

    // Status pulses, one cycle each; a bad-stop byte is never pushed so the
    // two can never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef CONSOLE_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err  <= w_frame_bad;
            r_overrun    <= w_push && w_full && !w_pop;
`ifdef CONSOLE_RX_PARITY_EN
            r_parity_err <= w_stop_sample && (^{r_shift, r_par_bit});
`endif
        end
    end

    // FIFO storage; contents need no reset because valid gates data_out.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
        end
    end

    // FIFO pointers, wrapping modulo 2*FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_console_rx.sv
// tb_console_rx: drives 8N1 frames into console_rx (CLKS_PER_BIT=16,
// FIFO_DEPTH=4) and checks the byte stream against an expected queue.
module tb_console_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data_out;
    logic       valid;
    logic [2:0] count;
    logic       frame_err;
    logic       overrun;
    logic [2:0] dbg_state;

    logic [7:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int fe_cycles = 0;
    int ov_cycles = 0;

    console_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data_out(data_out), .valid(valid),
        .ready(ready), .count(count), .frame_err(frame_err), .overrun(overrun),
        .o_dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: sample mid-cycle, score every pop and count status pulse cycles.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (frame_err) fe_cycles++;
                if (overrun) ov_cycles++;
                if (valid && ready) begin
                    if (exp_q.size() == 0) check("unexpected_pop", {31'b0, valid}, 32'd0);
                    else check("data_out", {24'b0, data_out}, {24'b0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Drive one frame; optionally raise ready only in the stop-sample cycle.
    task automatic send_byte(input logic [7:0] d, input logic stop, input logic store,
                             input logic rpulse);
        logic [9:0] frame;
        frame = {stop, d, 1'b0};
        if (store) exp_q.push_back(d);
        for (int b = 0; b < 10; b++) begin
            rx = frame[b];
            for (int i = 0; i < CPB; i++) begin
                if (b == 9 && rpulse) ready = (i == 10);
                if (b == 9 && i == 11) begin
                    check("idle_after_stop", {29'b0, dbg_state}, 32'd0);
                    check("valid_after_stop", {31'b0, valid}, {31'b0, exp_q.size() != 0});
                end
                @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", {31'b0, n >= 1000}, 32'd0);
    endtask

    initial begin
        int fe0, ov0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and long idle
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_data", {24'b0, data_out}, 32'd0);
        repeat (500) @(negedge clk);
        check("idle_valid", {31'b0, valid}, 32'd0);
        check("idle_count", {29'b0, count}, 32'd0);
        check("idle_fe", fe_cycles, 32'd0);
        check("idle_ov", ov_cycles, 32'd0);

        // Back-to-back frames
        send_byte(8'h55, 1'b1, 1'b1, 1'b0);
        send_byte(8'hA3, 1'b1, 1'b1, 1'b0);
        wait_drain();
        check("b2b_count", {29'b0, count}, 32'd0);

        // Short glitch then a real frame
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_state", {29'b0, dbg_state}, 32'd0);
        check("glitch_valid", {31'b0, valid}, 32'd0);
        send_byte(8'h3C, 1'b1, 1'b1, 1'b0);
        wait_drain();

        // Framing error
        fe0 = fe_cycles;
        ov0 = ov_cycles;
        send_byte(8'h7E, 1'b0, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("fe_pulse", fe_cycles - fe0, 32'd1);
        check("fe_no_ov", ov_cycles - ov0, 32'd0);
        check("fe_valid", {31'b0, valid}, 32'd0);
        check("fe_state", {29'b0, dbg_state}, 32'd0);

        // Overrun with consumer stalled
        ready = 1'b0;
        ov0 = ov_cycles;
        for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b1, k <= DEPTH, 1'b0);
        repeat (4) @(negedge clk);
        check("ovr_count", {29'b0, count}, 32'd4);
        check("ovr_pulse", ov_cycles - ov0, 32'd1);
        ready = 1'b1;
        wait_drain();
        check("ovr_drain_count", {29'b0, count}, 32'd0);

        // Push and pop in the same cycle while full
        ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) send_byte(8'h11 + 8'(k), 1'b1, 1'b1, 1'b0);
        check("full_count", {29'b0, count}, 32'd4);
        ov0 = ov_cycles;
        send_byte(8'h15, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("full_pp_count", {29'b0, count}, 32'd4);
        check("full_pp_no_ov", ov_cycles - ov0, 32'd0);
        ready = 1'b1;
        wait_drain();

        // Reset in the middle of a frame drops the partial byte
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            rx = b[0];
            repeat (CPB) @(negedge clk);
        end
        do_reset();
        check("midrst_count", {29'b0, count}, 32'd0);
        check("midrst_valid", {31'b0, valid}, 32'd0);
        repeat (300) @(negedge clk);
        check("midrst_state", {29'b0, dbg_state}, 32'd0);
        check("midrst_late_count", {29'b0, count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
